gtp_frame_rx: RTL and testbench
===============================

Name: gtp_frame_rx

Overview:
- Receive-side deframer for the inter-FPGA GTP serial links. It is the far end of the 16-bit 8b10b frame stream that the link transmitter sends on TX0..TX3.
- Consumes one lane's RX data path: RXDATA, RXCHARISK and code-error flags, all on the GTP user clock.
- Detects link-up, delineates frames, checks length and checksum, and presents payload words with start/end markers to downstream buffering.

Parameters:
- MAXLEN, 1024: maximum legal payload length in 16-bit words. Valid range is 1..MAXLEN.
- LOCKCNT, 16: number of consecutive idle words required to declare the link up.

Ports:
- CLK  input  1  GTP user clock (RXUSRCLK2 domain); all logic is on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- RXDATA  input  16  received word; byte 0 = [7:0].
- RXCHARISK  input  2  per-byte K-character flag.
- RXDISPERR  input  2  per-byte disparity error.
- RXNOTINTABLE  input  2  per-byte invalid code.
- RXLOSSOFSYNC  input  2  GTP loss-of-sync status; bit 1 = sync lost.
- LINK_UP  output  1  link established.
- DOUT  output  16  payload word.
- DVALID  output  1  DOUT valid this cycle.
- SOP  output  1  first payload word of a frame; qualifies DVALID.
- EOP  output  1  last payload word of a frame; qualifies DVALID.
- FRAME_OK  output  1  one-cycle pulse: frame completed correctly.
- FRAME_ERR  output  1  one-cycle pulse: frame aborted or bad.
- ERRCNT  output  16  saturating code-error counter.

Behaviour:
- Word codes, all with RXCHARISK = 2'b01:
  - IDLE = 16'h50BC (K28.5 + D16.2).
  - SOF = {tag[7:0], 8'hFB} (K27.7).
  - EOF = {csum[7:0], 8'hFD} (K29.7).
- Frame layout: SOF, LEN word (data, value L), L payload words (CHARISK = 00), EOF.
- csum = 8-bit XOR of both bytes of every payload word.
- "Code error" = any bit of RXDISPERR or RXNOTINTABLE set.
- Reset values: all outputs 0; state LINKDOWN; internal counters 0.
- States and transitions:
  - LINKDOWN: count consecutive IDLE words with no code error. Any other word clears the count. When the count reaches LOCKCNT, go to IDLE and set LINK_UP on that edge.
  - IDLE: SOF -> LEN. IDLE words are ignored. Any other K word or data word is ignored with no error.
  - LEN: a data word with 1 <= L <= MAXLEN latches L and clears the checksum, then -> DATA. Otherwise pulse FRAME_ERR and -> IDLE.
  - DATA: each data word is output with DVALID = 1 and folded into the checksum.
    - SOP is set on the first payload word; EOP is set on the L-th payload word, which then goes to EOF.
    - L = 1 sets SOP and EOP together.
  - EOF: an EOF word with matching csum pulses FRAME_OK; a mismatched csum or any other word pulses FRAME_ERR. Go to IDLE in both cases.
- Latency: DOUT/DVALID/SOP/EOP are registered, one cycle after the RXDATA word. FRAME_OK/FRAME_ERR are one cycle after the EOF word, i.e. one cycle after the EOP-qualified word if EOF arrives back-to-back.
- Aborts inside LEN/DATA/EOF:
  - A K word in DATA pulses FRAME_ERR and goes to IDLE.
  - An SOF in DATA or EOF pulses FRAME_ERR and goes to LEN, so the new frame is accepted.
  - A code error pulses FRAME_ERR and goes to IDLE.
- An aborted frame never produces EOP; downstream discards on FRAME_ERR.
- Loss of link: RXLOSSOFSYNC[1] = 1 in any state -> LINKDOWN and LINK_UP = 0 on the next edge. A frame in progress is aborted with FRAME_ERR.
- ERRCNT increments on every word with a code error while LINK_UP = 1. It saturates at 16'hFFFF and is cleared only by reset.
- FRAME_OK and FRAME_ERR are never both set. DVALID is 0 outside DATA.
- Asserting RST_N mid-frame clears everything immediately; no FRAME_ERR is emitted.

Optional Feature:
- Macro GTPRX_CSUM_EN.
- Defined: EOF csum is compared as above.
- Undefined: the EOF high byte is ignored, so any EOF word in state EOF gives FRAME_OK. The checksum register is not synthesized.

Test Plan:
- 16 IDLE words after reset, LOCKCNT = 16 -> LINK_UP rises on the edge after the 16th; 15 IDLE words followed by 16'h1234 -> LINK_UP stays 0.
- Link up, then SOF 16'h07FB, LEN 3, data 16'h0102, 16'h0304, 16'h0506, EOF 16'h07FD -> three DVALID cycles with SOP on 0102 and EOP on 0506, then a FRAME_OK pulse. Same stimulus with EOF 16'h00FD and GTPRX_CSUM_EN defined -> FRAME_ERR.
- LEN = 0 and LEN = MAXLEN+1 -> FRAME_ERR, no DVALID. LEN = 1 with data 16'hAAAA and EOF 16'h00FD -> SOP and EOP in the same cycle, then FRAME_OK.
- SOF injected after the 2nd payload word of a LEN = 4 frame -> FRAME_ERR, and the following frame is received correctly with FRAME_OK.
- RXDISPERR = 2'b01 on a payload word -> FRAME_ERR and ERRCNT = 1; RXLOSSOFSYNC[1] = 1 mid-frame -> FRAME_ERR, LINK_UP = 0, and relock needs LOCKCNT idles.
- 70000 code-error words while link up (relocking as needed) -> ERRCNT holds at 16'hFFFF. RST_N low mid-frame -> all outputs 0 with no FRAME_ERR pulse.

Source files
------------

// File: rtl/gtp_frame_rx.sv
// gtp_frame_rx: GTP lane deframer (link lock, frame delineation, length/checksum check).
// Define GTPRX_CSUM_EN to compare the EOF checksum byte; otherwise any EOF completes the frame.
module gtp_frame_rx #(
    parameter int MAXLEN  = 1024,
    parameter int LOCKCNT = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] RXDATA,
    input  logic [1:0]  RXCHARISK,
    input  logic [1:0]  RXDISPERR,
    input  logic [1:0]  RXNOTINTABLE,
    input  logic [1:0]  RXLOSSOFSYNC,
    output logic        LINK_UP,
    output logic [15:0] DOUT,
    output logic        DVALID,
    output logic        SOP,
    output logic        EOP,
    output logic        FRAME_OK,
    output logic        FRAME_ERR,
    output logic [15:0] ERRCNT
);
    localparam int LW = $clog2(MAXLEN + 1);
    localparam int CW = $clog2(LOCKCNT + 1);
    localparam logic [2:0] S_LINKDOWN = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_LEN      = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_EOF      = 3'd4;

    logic [2:0]    state, state_nx;
    logic [CW-1:0] lock_cnt, lock_nx;
    logic [LW-1:0] len, cnt;
    logic          ok_nx, err_nx, dv_nx, csum_ok;
    logic          unused_los0;

    wire k0       = RXCHARISK == 2'b01;
    wire is_data  = RXCHARISK == 2'b00;
    wire is_idle  = k0 && RXDATA == 16'h50BC;
    wire is_sof   = k0 && RXDATA[7:0] == 8'hFB;
    wire is_eof   = k0 && RXDATA[7:0] == 8'hFD;
    wire code_err = |{RXDISPERR, RXNOTINTABLE};
    wire los      = RXLOSSOFSYNC[1];
    wire len_ok   = is_data && RXDATA != 16'd0 && RXDATA <= 16'(MAXLEN);
    wire last     = cnt == len - LW'(1);
    wire in_frame = state == S_LEN || state == S_DATA || state == S_EOF;

    assign unused_los0 = RXLOSSOFSYNC[0];

`ifdef GTPRX_CSUM_EN
    logic [7:0] csum;
    assign csum_ok = csum == RXDATA[15:8];
`else
    assign csum_ok = 1'b1;
`endif

    // Priority: loss of sync, then code error inside a frame, then per-state decode.
    always_comb begin
        state_nx = state;
        lock_nx  = lock_cnt;
        ok_nx    = 1'b0;
        err_nx   = 1'b0;
        dv_nx    = 1'b0;
        if (los) begin
            state_nx = S_LINKDOWN;
            lock_nx  = '0;
            err_nx   = in_frame;
        end else if (state == S_LINKDOWN) begin
            lock_nx  = (is_idle && !code_err) ? lock_cnt + 1'b1 : '0;
            if (is_idle && !code_err && lock_cnt == CW'(LOCKCNT - 1)) begin
                state_nx = S_IDLE;
                lock_nx  = '0;
            end
        end else if (code_err && in_frame) begin
            state_nx = S_IDLE;
            err_nx   = 1'b1;
        end else begin
            case (state)
                S_IDLE: state_nx = is_sof ? S_LEN : S_IDLE;
                S_LEN: begin
                    state_nx = len_ok ? S_DATA : S_IDLE;
                    err_nx   = !len_ok;
                end
                S_DATA: begin
                    dv_nx    = is_data;
                    err_nx   = !is_data;
                    state_nx = is_data ? (last ? S_EOF : S_DATA) : (is_sof ? S_LEN : S_IDLE);
                end
                S_EOF: begin
                    ok_nx    = is_eof && csum_ok;
                    err_nx   = !(is_eof && csum_ok);
                    state_nx = is_sof ? S_LEN : S_IDLE;
                end
                default: state_nx = S_LINKDOWN;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_LINKDOWN;
            lock_cnt  <= '0;
            len       <= '0;
            cnt       <= '0;
            LINK_UP   <= 1'b0;
            DOUT      <= '0;
            DVALID    <= 1'b0;
            SOP       <= 1'b0;
            EOP       <= 1'b0;
            FRAME_OK  <= 1'b0;
            FRAME_ERR <= 1'b0;
            ERRCNT    <= '0;
        end else begin
            state     <= state_nx;
            lock_cnt  <= lock_nx;
            LINK_UP   <= state_nx != S_LINKDOWN;
            DOUT      <= dv_nx ? RXDATA : '0;
            DVALID    <= dv_nx;
            SOP       <= dv_nx && cnt == '0;
            EOP       <= dv_nx && last;
            FRAME_OK  <= ok_nx;
            FRAME_ERR <= err_nx;
            if (state == S_LEN && state_nx == S_DATA) begin
                len <= RXDATA[LW-1:0];
                cnt <= '0;
            end else if (dv_nx) begin
                cnt <= cnt + 1'b1;
            end
            if (code_err && LINK_UP && ERRCNT != 16'hFFFF)
                ERRCNT <= ERRCNT + 1'b1;
        end
    end

`ifdef GTPRX_CSUM_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            csum <= '0;
        else if (state == S_LEN && state_nx == S_DATA)
            csum <= '0;
        else if (dv_nx)
            csum <= csum ^ RXDATA[15:8] ^ RXDATA[7:0];
    end
`endif
endmodule

// File: tb/tb_gtp_frame_rx.sv
// tb_gtp_frame_rx: scoreboard bench for gtp_frame_rx (payload and frame-status queues).
module tb_gtp_frame_rx;
    localparam logic [1:0] EV_OK  = 2'b10;
    localparam logic [1:0] EV_ERR = 2'b01;
`ifdef GTPRX_CSUM_EN
    localparam logic [1:0] EV_BADSUM = EV_ERR;
`else
    localparam logic [1:0] EV_BADSUM = EV_OK;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] RXDATA = '0;
    logic [1:0]  RXCHARISK = '0;
    logic [1:0]  RXDISPERR = '0;
    logic [1:0]  RXNOTINTABLE = '0;
    logic [1:0]  RXLOSSOFSYNC = '0;
    logic        LINK_UP, DVALID, SOP, EOP, FRAME_OK, FRAME_ERR;
    logic [15:0] DOUT, ERRCNT;

    int errors = 0;
    int checks = 0;
    logic [17:0] dq[$];
    logic [1:0]  eq[$];

    gtp_frame_rx dut (
        .CLK(CLK), .RST_N(RST_N), .RXDATA(RXDATA), .RXCHARISK(RXCHARISK),
        .RXDISPERR(RXDISPERR), .RXNOTINTABLE(RXNOTINTABLE), .RXLOSSOFSYNC(RXLOSSOFSYNC),
        .LINK_UP(LINK_UP), .DOUT(DOUT), .DVALID(DVALID), .SOP(SOP), .EOP(EOP),
        .FRAME_OK(FRAME_OK), .FRAME_ERR(FRAME_ERR), .ERRCNT(ERRCNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] k,
                        input logic [1:0] de = 2'b00, input logic los = 1'b0);
        RXDATA       = d;
        RXCHARISK    = k;
        RXDISPERR    = de;
        RXNOTINTABLE = 2'b00;
        RXLOSSOFSYNC = {los, 1'b0};
        @(posedge CLK);
        #1;
    endtask

    task automatic lock();
        repeat (15) send(16'h50BC, 2'b01);
        chk("lock15", {31'd0, LINK_UP}, 0);
        send(16'h50BC, 2'b01);
        chk("lock16", {31'd0, LINK_UP}, 1);
    endtask

    // LEN word, payload base+i*0x0202, EOF with computed csum or forced byte eofb.
    task automatic body(input int len, input logic [15:0] base, input int eofb);
        logic [7:0]  cs;
        logic [7:0]  eb;
        logic [15:0] w;
        cs = 8'h00;
        send(16'(len), 2'b00);
        for (int i = 0; i < len; i++) begin
            w  = base + 16'(i) * 16'h0202;
            cs = cs ^ w[15:8] ^ w[7:0];
            dq.push_back({w, i == 0, i == len - 1});
            send(w, 2'b00);
        end
        eb = (eofb < 0) ? cs : 8'(eofb);
        eq.push_back(eb == cs ? EV_OK : EV_BADSUM);
        send({eb, 8'hFD}, 2'b01);
    endtask

    always @(negedge CLK) begin
        if (DVALID) begin
            if (dq.size() == 0) chk("dv_extra", {31'd0, DVALID}, 0);
            else chk("payload", {14'd0, DOUT, SOP, EOP}, {14'd0, dq.pop_front()});
        end else if (SOP || EOP) begin
            chk("sopeop_nodv", {30'd0, SOP, EOP}, 0);
        end
        if (FRAME_OK || FRAME_ERR) begin
            if (eq.size() == 0) chk("frame_extra", {30'd0, FRAME_OK, FRAME_ERR}, 0);
            else chk("frame", {30'd0, FRAME_OK, FRAME_ERR}, {30'd0, eq.pop_front()});
        end
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out", {LINK_UP, DVALID, SOP, EOP, FRAME_OK, FRAME_ERR, DOUT}, 0);
        chk("rst_errcnt", {16'd0, ERRCNT}, 0);
        RST_N = 1'b1;

        repeat (15) send(16'h50BC, 2'b01);
        send(16'h1234, 2'b00);
        chk("nolock", {31'd0, LINK_UP}, 0);
        lock();

        send(16'h07FB, 2'b01);
        body(3, 16'h0102, -1);
        repeat (3) send(16'h50BC, 2'b01);
        send(16'h07FB, 2'b01);
        body(3, 16'h0102, 0);
        repeat (3) send(16'h50BC, 2'b01);

        send(16'h01FB, 2'b01);
        eq.push_back(EV_ERR);
        send(16'd0, 2'b00);
        send(16'h01FB, 2'b01);
        eq.push_back(EV_ERR);
        send(16'd1025, 2'b00);
        repeat (3) send(16'h50BC, 2'b01);

        send(16'h03FB, 2'b01);
        body(1, 16'hAAAA, -1);
        send(16'h04FB, 2'b01);
        body(1024, 16'h0001, -1);
        repeat (3) send(16'h50BC, 2'b01);

        send(16'h05FB, 2'b01);
        send(16'd4, 2'b00);
        dq.push_back({16'h1111, 1'b1, 1'b0});
        send(16'h1111, 2'b00);
        dq.push_back({16'h2222, 1'b0, 1'b0});
        send(16'h2222, 2'b00);
        eq.push_back(EV_ERR);
        send(16'h06FB, 2'b01);
        body(2, 16'h3333, -1);
        repeat (3) send(16'h50BC, 2'b01);

        send(16'h08FB, 2'b01);
        send(16'd3, 2'b00);
        dq.push_back({16'h4444, 1'b1, 1'b0});
        send(16'h4444, 2'b00);
        eq.push_back(EV_ERR);
        send(16'h5555, 2'b00, 2'b01);
        chk("errcnt1", {16'd0, ERRCNT}, 1);
        repeat (3) send(16'h50BC, 2'b01);

        send(16'h09FB, 2'b01);
        send(16'd3, 2'b00);
        dq.push_back({16'h6666, 1'b1, 1'b0});
        send(16'h6666, 2'b00);
        eq.push_back(EV_ERR);
        send(16'h50BC, 2'b01, 2'b00, 1'b1);
        chk("los_down", {31'd0, LINK_UP}, 0);
        lock();

        repeat (100) send(16'h0000, 2'b00, 2'b10);
        chk("errcnt101", {16'd0, ERRCNT}, 101);
        repeat (69900) send(16'h0000, 2'b00, 2'b10);
        chk("errcnt_sat", {16'd0, ERRCNT}, 32'hFFFF);
        chk("sat_linkup", {31'd0, LINK_UP}, 1);

        send(16'h0AFB, 2'b01);
        send(16'd3, 2'b00);
        dq.push_back({16'h7777, 1'b1, 1'b0});
        send(16'h7777, 2'b00);
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        chk("midrst_out", {LINK_UP, DVALID, SOP, EOP, FRAME_OK, FRAME_ERR, DOUT}, 0);
        chk("midrst_errcnt", {16'd0, ERRCNT}, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (4) send(16'h50BC, 2'b01);
        chk("post_rst_link", {31'd0, LINK_UP}, 0);

        chk("dq_empty", dq.size(), 0);
        chk("eq_empty", eq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
